// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_pkg                                                   |
// | Purpose  : Shared types and helpers for the FIFO-draining UART TX.        |
// |            Holds the transmitter state encoding and the frame-length     |
// |            helper used by anything that needs frame timing.              |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package uart_tx_pkg;

    // Transmitter states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Frame length for the default configuration (8N1 at 234 clocks per bit).
    localparam int c_FRAME_CLKS_DEFAULT = (1 + 8 + 1) * 234;

    // Clock cycles per frame for an arbitrary configuration. Evaluated only
    // at elaboration time or in benches, never as hardware.
    function automatic int frameClks(input int dataWidth,
                                     input int clksPerBit,
                                     input int stopBits);
        return (1 + dataWidth + stopBits) * clksPerBit;
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_uart_tx_if                                               |
// | Purpose  : Read-side bundle of a first-word-fall-through FIFO.           |
// | Signals  : fifoEmptyIn       - FIFO empty flag (FIFO -> consumer)        |
// |            fifoDataIn        - head word, valid while not empty          |
// |            fifoReadEnableOut - 1-cycle pop strobe (consumer -> FIFO)     |
// | Modports : master - the consumer (UART transmitter)                      |
// |            slave  - the FIFO read port                                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  fifoEmptyIn;
    logic [DATA_WIDTH-1:0] fifoDataIn;
    logic                  fifoReadEnableOut;

    modport master (
        input  fifoEmptyIn,
        input  fifoDataIn,
        output fifoReadEnableOut
    );

    modport slave (
        output fifoEmptyIn,
        output fifoDataIn,
        input  fifoReadEnableOut
    );

endinterface : fifo_uart_tx_if
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : baud_tick_gen                                                 |
// | Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last |
// |            cycle of each bit period; restartIn realigns the count so the |
// |            first tick lands CLKS_PER_BIT cycles after the restart edge.  |
// | Ports    : clkIn     - clock                                             |
// |            resetIn   - synchronous active-high reset                     |
// |            restartIn - restart the bit period at the next edge           |
// |            tickOut   - high during the final cycle of each bit period    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 234
) (
    input  wire logic clkIn,
    input  wire logic resetIn,
    input  wire logic restartIn,
    output logic      tickOut
);

    localparam int                  c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clkIn) begin
        if (resetIn || restartIn) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // The tick marks the last cycle of a bit, so the FSM's transition on
    // that edge starts the next bit exactly CLKS_PER_BIT cycles later.
    assign tickOut = (r_count == c_LAST);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                                  |
// | Purpose  : Pops words from a FWFT FIFO and serialises them on a UART     |
// |            line (start bit, LSB-first data, STOP_BITS stop bits).        |
// |            Back-to-back words are sent with no idle gap.                 |
// | Ports    : clkIn       - clock, all logic on rising edge                 |
// |            resetIn     - synchronous active-high reset                   |
// |            enableIn    - permits fetching new words                      |
// |            fifoBus     - FIFO read side (master modport)                 |
// |            txOut       - registered serial line, idle high               |
// |            busyOut     - high while a frame is in flight                 |
// |            wordDoneOut - 1-cycle pulse after the final stop bit          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 234,
    parameter int STOP_BITS    = 1
) (
    input  wire logic       clkIn,
    input  wire logic       resetIn,
    input  wire logic       enableIn,
    fifo_uart_tx_if.master  fifoBus,
    output logic            txOut,
    output logic            busyOut,
    output logic            wordDoneOut
);

    localparam int                 c_BIT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);

    tx_state_t             r_state;
    tx_state_t             w_stateNext;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shiftNext;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [c_BIT_W-1:0]    r_bitCnt;
    logic [c_BIT_W-1:0]    w_bitCntNext;
    logic                  r_tx;
    logic                  w_txNext;
    logic                  r_readEn;
    logic                  w_readEnNext;
    logic                  r_wordDone;
    logic                  w_wordDoneNext;
    logic                  w_restart;
    logic                  w_decide;
    logic                  w_fetchOk;
    logic                  w_tick;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clkIn     (clkIn),
        .resetIn   (resetIn),
        .restartIn (w_restart),
        .tickOut   (w_tick)
    );

    assign w_fetchOk = enableIn && !fifoBus.fifoEmptyIn;
    assign w_shifted = r_shift >> 1;

    // State register and registered outputs.
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_tx       <= 1'b1;
            r_readEn   <= 1'b0;
            r_wordDone <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shift    <= w_shiftNext;
            r_bitCnt   <= w_bitCntNext;
            r_tx       <= w_txNext;
            r_readEn   <= w_readEnNext;
            r_wordDone <= w_wordDoneNext;
        end
    end

    // Next-state and next-output logic. The bit counter is reused in
    // TX_STOP to count stop bits, so no stop-length multiply is needed.
    always_comb begin
        w_stateNext    = r_state;
        w_shiftNext    = r_shift;
        w_bitCntNext   = r_bitCnt;
        w_txNext       = r_tx;
        w_readEnNext   = 1'b0;
        w_wordDoneNext = 1'b0;
        w_restart      = 1'b0;
        w_decide       = 1'b0;

        unique case (r_state)
            TX_IDLE: begin
                w_decide = 1'b1;
            end

            TX_START: begin
                if (w_tick) begin
                    w_stateNext  = TX_DATA;
                    w_txNext     = r_shift[0];
                    w_bitCntNext = '0;
                end
            end

            TX_DATA: begin
                if (w_tick) begin
                    if (r_bitCnt == c_LAST_DATA) begin
                        w_stateNext  = TX_STOP;
                        w_txNext     = 1'b1;
                        w_bitCntNext = '0;
                    end else begin
                        w_shiftNext  = w_shifted;
                        w_txNext     = w_shifted[0];
                        w_bitCntNext = r_bitCnt + 1'b1;
                    end
                end
            end

            TX_STOP: begin
                if (w_tick) begin
                    if (r_bitCnt == c_LAST_STOP) begin
                        w_wordDoneNext = 1'b1;
                        w_decide       = 1'b1;
                    end else begin
                        w_bitCntNext = r_bitCnt + 1'b1;
                    end
                end
            end

            default: begin
                w_stateNext = TX_IDLE;
                w_txNext    = 1'b1;
            end
        endcase

        // Shared fetch decision: from idle, or on the last stop-bit cycle so
        // the next start bit follows without a gap.
        if (w_decide) begin
            if (w_fetchOk) begin
                w_stateNext  = TX_START;
                w_shiftNext  = fifoBus.fifoDataIn;
                w_bitCntNext = '0;
                w_txNext     = 1'b0;
                w_readEnNext = 1'b1;
                w_restart    = 1'b1;
            end else begin
                w_stateNext  = TX_IDLE;
                w_txNext     = 1'b1;
            end
        end
    end

    assign txOut                     = r_tx;
    assign busyOut                   = (r_state != TX_IDLE);
    assign wordDoneOut               = r_wordDone;
    assign fifoBus.fifoReadEnableOut = r_readEn;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_uart_tx                                               |
// | Purpose  : Directed self-checking bench for fifo_uart_tx at 4 clocks per |
// |            bit, 8 data bits, 1 stop bit (40-cycle frame).                |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fifo_uart_tx;

    localparam int c_CPB   = 4;
    localparam int c_FRAME = 40;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic w_tx;
    logic w_busy;
    logic w_done;
    logic [3:0] w_obs;

    logic [7:0] q[$];
    int popCount;
    int nChecks;
    int nErrors;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) fifoBus ();

    fifo_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (c_CPB),
        .STOP_BITS    (1)
    ) dut (
        .clkIn       (clk),
        .resetIn     (rst),
        .enableIn    (enable),
        .fifoBus     (fifoBus),
        .txOut       (w_tx),
        .busyOut     (w_busy),
        .wordDoneOut (w_done)
    );

    // Observed output vector: {txOut, busyOut, fifoReadEnableOut, wordDoneOut}
    assign w_obs = {w_tx, w_busy, fifoBus.fifoReadEnableOut, w_done};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refreshFifo();
        fifoBus.fifoEmptyIn = (q.size() == 0);
        fifoBus.fifoDataIn  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        q.push_back(d);
        refreshFifo();
    endtask

    // One clock; the FIFO model pops on the edge that ends a pop-strobe cycle.
    task automatic step();
        logic reBefore;
        reBefore = fifoBus.fifoReadEnableOut;
        @(posedge clk);
        #1;
        if (reBefore === 1'b1) begin
            if (q.size() != 0) void'(q.pop_front());
            popCount++;
        end
        refreshFifo();
    endtask

    task automatic waitFetch(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (fifoBus.fifoReadEnableOut !== 1'b1 && n < maxCycles) begin
            step();
            n++;
        end
        checkVal(tag, {31'd0, fifoBus.fifoReadEnableOut}, 32'd1);
    endtask

    // Checks the 40 cycles of one frame starting at the pop-strobe cycle.
    task automatic checkFrame(input string tag, input logic [7:0] d,
                              input bit startsWithDone, input int enableOffAt);
        for (int k = 0; k < c_FRAME; k++) begin
            int b;
            logic expTx;
            logic [3:0] expVec;
            b = k / c_CPB;
            if (b == 0)      expTx = 1'b0;
            else if (b <= 8) expTx = d[b-1];
            else             expTx = 1'b1;
            if (k == enableOffAt) enable = 1'b0;
            expVec = {expTx, 1'b1, (k == 0), (k == 0) && startsWithDone};
            checkVal($sformatf("%s_k%0d", tag, k), {28'd0, w_obs}, {28'd0, expVec});
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nChecks  = 0;
        nErrors  = 0;
        popCount = 0;
        rst      = 1'b1;
        enable   = 1'b1;
        q.delete();
        push(8'hA5);

        // 1: reset held with a non-empty FIFO
        step();
        checkVal("rst_c1", {28'd0, w_obs}, 32'h8);
        step();
        checkVal("rst_c2", {28'd0, w_obs}, 32'h8);

        // 2: single frame 0xA5
        rst = 1'b0;
        waitFetch("t2_fetch", 3);
        checkFrame("t2", 8'hA5, 1'b0, -1);
        checkVal("t2_end", {28'd0, w_obs}, 32'h9);
        checkVal("t2_pops", popCount, 1);
        step();
        checkVal("t2_idle", {28'd0, w_obs}, 32'h8);

        // 3: back-to-back 0x00 then 0xFF
        push(8'h00);
        push(8'hFF);
        waitFetch("t3_fetch", 3);
        checkFrame("t3a", 8'h00, 1'b0, -1);
        checkFrame("t3b", 8'hFF, 1'b1, -1);
        checkVal("t3_end", {28'd0, w_obs}, 32'h9);
        checkVal("t3_pops", popCount, 3);

        // 4: enable dropped during data bits of frame 1
        push(8'h11);
        push(8'h22);
        push(8'h33);
        waitFetch("t4_fetch", 3);
        checkFrame("t4", 8'h11, 1'b0, 12);
        checkVal("t4_end", {28'd0, w_obs}, 32'h9);
        for (int i = 0; i < 20; i++) begin
            step();
            checkVal($sformatf("t4_idle%0d", i), {28'd0, w_obs}, 32'h8);
        end
        checkVal("t4_pops", popCount, 4);
        q.delete();
        refreshFifo();
        enable = 1'b1;

        // 5: reset in data bit 3 of 0x5A, then next word 0x3C
        push(8'h5A);
        push(8'h3C);
        waitFetch("t5_fetch", 3);
        for (int i = 0; i < 17; i++) step();
        checkVal("t5_bit3", {31'd0, w_tx}, 32'd1);
        rst = 1'b1;
        step();
        checkVal("t5_rst", {28'd0, w_obs}, 32'h8);
        rst = 1'b0;
        waitFetch("t5_refetch", 3);
        checkVal("t5_pops_mid", popCount, 5);
        checkFrame("t5", 8'h3C, 1'b0, -1);
        checkVal("t5_end", {28'd0, w_obs}, 32'h9);
        checkVal("t5_pops", popCount, 6);

        // 6: empty FIFO with enable high, then a late word
        for (int i = 0; i < 100; i++) begin
            step();
            checkVal($sformatf("t6_empty%0d", i), {28'd0, w_obs}, 32'h8);
        end
        push(8'h96);
        step();
        checkVal("t6_start", {28'd0, w_obs}, 32'h6);
        checkFrame("t6", 8'h96, 1'b0, -1);
        checkVal("t6_end", {28'd0, w_obs}, 32'h9);
        checkVal("t6_pops", popCount, 7);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Consumer for the read side of the team's FIFO: pops one word at a time from a first-word-fall-through FIFO and transmits it on a UART line. The format is 8N1 by default: start bit, LSB-first data, stop bit(s). It sits between the FIFO and the board TX pin, so buffered bytes drain to the host without CPU involvement.

Parameters:
DATA_WIDTH, 8, bits per word; equals the FIFO word width.
CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); must be >= 2.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clkIn  input  1  system clock; all logic on rising edge.
resetIn  input  1  synchronous, active-high reset.
enableIn  input  1  permits fetching new words; sampled only when a fetch decision is made.
fifoEmptyIn  input  1  FIFO empty flag.
fifoDataIn  input  DATA_WIDTH  FIFO head word, valid whenever fifoEmptyIn=0.
fifoReadEnableOut  output  1  pop strobe; exactly one 1-cycle pulse per word fetched.
txOut  output  1  serial line, idle high, registered.
busyOut  output  1  high from the fetch cycle until the last stop-bit cycle ends.
wordDoneOut  output  1  1-cycle pulse when a frame's final stop bit completes.

Behaviour:
- Reset is synchronous and active-high. One clock, clkIn; resetIn is sampled on its rising edge.
- Reset values: txOut=1, fifoReadEnableOut=0, busyOut=0, wordDoneOut=0, state=TX_IDLE, bit and baud counters=0, shift register=0.
- Reset has priority over everything and may arrive mid-frame. On reset the frame is aborted, txOut returns to 1 on the next cycle, and no pop or wordDone is issued.
- States: TX_IDLE, TX_START, TX_DATA, TX_STOP.
- Fetch decision, made in TX_IDLE and on the final cycle of TX_STOP: if enableIn=1 and fifoEmptyIn=0 at edge N:
  - latch fifoDataIn into the shift register;
  - fifoReadEnableOut=1 during cycle N+1 only;
  - state becomes TX_START; txOut=0 and busyOut=1 from cycle N+1.
- Otherwise the state goes to (or stays in) TX_IDLE, with txOut=1 and busyOut=0.
- TX_START: txOut=0 for CLKS_PER_BIT cycles, then TX_DATA.
- TX_DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles. After the last bit, go to TX_STOP.
- TX_STOP: txOut=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, wordDoneOut pulses for 1 cycle (the cycle after that edge) and the fetch decision is made.
- Frame length is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- Back-to-back frames have zero idle gap: the next start bit immediately follows the stop bit.
- enableIn deasserted mid-frame: the current frame completes normally, then no new fetch.
- The FIFO going empty mid-frame has no effect; the word is already latched.
- fifoDataIn is sampled only on fetch edges; changes at other times are ignored.
- Baud counter counts 0..CLKS_PER_BIT-1 and restarts at every bit boundary and every fetch. Width is $clog2(CLKS_PER_BIT). Bit counter width is $clog2(DATA_WIDTH+1).
- No divide or multiply in hardware; STOP_BITS*CLKS_PER_BIT is an elaboration-time constant.

Decomposition:
- Package uart_tx_pkg: typedef enum tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_STOP}, plus a localparam computing the frame length for benches.
- Sub-module baud_tick_gen (parameter CLKS_PER_BIT; ports clkIn, resetIn, restartIn, tickOut). It gives a 1-cycle tick every CLKS_PER_BIT cycles after restart.
- The FSM, shift register and bit counter stay in fifo_uart_tx.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 (frame = 40 cycles).
1. Assert resetIn for 2 cycles with a non-empty FIFO -> txOut=1, busyOut=0, fifoReadEnableOut=0, wordDoneOut=0 throughout.
2. FIFO holds 0xA5, enableIn=1 -> exactly one pop pulse, and txOut follows bits 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. wordDoneOut pulses at cycle 40 after the pop; busyOut then drops.
3. FIFO holds 0x00 then 0xFF -> two pops 40 cycles apart, no idle-high gap between the stop bit and the second start bit, and two wordDone pulses.
4. FIFO holds 3 words, enableIn dropped during frame 1's data bits -> frame 1 completes, only 1 pop total, txOut=1 afterwards.
5. resetIn pulsed during data bit 3 of 0x5A -> txOut=1 the next cycle, no wordDone. With enableIn=1 after reset, the next FIFO word is fetched and transmitted with a correct frame.
6. fifoEmptyIn=1 with enableIn=1 for 100 cycles -> no pop, txOut=1, busyOut=0. Data going non-empty later starts a frame 1 cycle after the fetch edge.
